// File: rtl/b13_serial_rx.sv
// Receiver for the b13 serial transmitter: cycle-exact slot sampling of an 8-bit MSB-first frame,
// stop-slot check, and a small byte FIFO read with a valid/ack handshake plus dsr flow control.
module b13_serial_rx #(
    parameter int DELAY_TIME = 104,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       serial_in,
    output logic       dsr,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ack,
    input  logic       err_clr,
    output logic       frame_error,
    output logic       overrun,
    output logic       busy
);

    localparam int          AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int          CW        = AW + 1;
    localparam logic [9:0]  SLOT_LAST = 10'(DELAY_TIME + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW:0] DEPTH_W   = (CW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        STOP
    } state_t;

    state_t          state_q, state_d;
    logic [9:0]      slot_cnt_q, slot_cnt_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [7:0]      mem_d [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            frame_error_q, frame_error_d;
    logic            overrun_q, overrun_d;

    logic            slot_hit;
    logic            push_req;
    logic            frame_bad;
    logic            pop;
    logic            push_ok;
    logic [CW:0]     occupancy;

    assign slot_hit = (slot_cnt_q == SLOT_LAST);

    // Frame FSM: the start pulse aligns the slot counter so every sample lands on the transmitter's slot edge.
    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        slot_cnt_d = slot_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        push_req   = 1'b0;
        frame_bad  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!serial_in) begin
                    state_d    = DATA;
                    slot_cnt_d = '0;
                    bit_cnt_d  = '0;
                end
            end
            DATA: begin
                if (slot_hit) begin
                    slot_cnt_d                   = '0;
                    shift_d[3'd7 - bit_cnt_q]    = serial_in;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end else begin
                    slot_cnt_d = slot_cnt_q + 10'd1;
                end
            end
            STOP: begin
                if (slot_hit) begin
                    slot_cnt_d = '0;
                    bit_cnt_d  = '0;
                    state_d    = IDLE;
                    if (serial_in) begin
                        push_req = 1'b1;
                    end else begin
                        frame_bad = 1'b1;
                    end
                end else begin
                    slot_cnt_d = slot_cnt_q + 10'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FIFO: a pop frees the head slot first, so a same-edge push into a full FIFO is accepted.
    always_comb begin
        mem_d         = mem_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        pop           = rx_ack && (count_q != '0);
        push_ok       = push_req && ((count_q != DEPTH_C) || pop);
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push_ok) begin
            mem_d[wr_ptr_q] = shift_q;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (push_ok && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push_ok) begin
            count_d = count_q - CW'(1);
        end
        // A new error on the same edge as err_clr must survive the clear.
        frame_error_d = (frame_error_q && !err_clr) || frame_bad;
        overrun_d     = (overrun_q && !err_clr) || (push_req && !push_ok);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            slot_cnt_q    <= '0;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            frame_error_q <= 1'b0;
            overrun_q     <= 1'b0;
            // NOTE: the byte store is reset because rx_data reads it directly and must be 0 out of reset.
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            slot_cnt_q    <= slot_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            frame_error_q <= frame_error_d;
            overrun_q     <= overrun_d;
            mem_q         <= mem_d;
        end
    end

    // dsr reserves room for the frame in flight; it depends on registers only.
    assign occupancy   = {1'b0, count_q} + {{CW{1'b0}}, busy};
    assign dsr         = (occupancy < DEPTH_W);
    assign busy        = (state_q != IDLE);
    assign rx_valid    = (count_q != '0);
    assign rx_data     = mem_q[rd_ptr_q];
    assign frame_error = frame_error_q;
    assign overrun     = overrun_q;

endmodule
